// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 constants: FSM encoding, frame layout, command bytes
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int PS2_DATA_BITS = 8;
  localparam int PS2_STOP_IDX  = 9;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // Data byte with odd parity above it, shifted out LSB first.
  function automatic logic [PS2_DATA_BITS:0] ps2_frame(input logic [PS2_DATA_BITS-1:0] d);
    return {~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - PS/2 line synchronizer with registered falling-edge detect
module ps2_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              fall_q;

  // Idle PS/2 lines are pulled high, so the chain resets to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(line_i);
      prev_q <= sync_q[STAGES-1];
      fall_q <= prev_q & ~sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter
// Optional: define PS2_TX_RETRY_EN to re-run a NACKed or timed-out transfer once.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 6000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       STOP_IDX = 4'(PS2_STOP_IDX);

  logic clk_level, clk_fall, dat_level, dat_fall_unused;

  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (ps2_clk_in),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.STAGES(SYNC_STAGES)) u_dat_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .line_i  (ps2_dat_in),
    .level_o (dat_level),
    .fall_o  (dat_fall_unused)
  );

  logic [2:0]             state_q, state_d;
  logic [PS2_DATA_BITS:0] shreg_q, shreg_d;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   dat_oe_q, dat_oe_d;
  logic                   nack_q, nack_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   wd_hit, pass, fail;
`ifdef PS2_TX_RETRY_EN
  logic                   retry_q, retry_d;
`endif

  assign busy       = (state_q != ST_IDLE) | done_q;
  assign tx_ready   = ~busy;
  assign tx_done    = done_q;
  assign tx_err     = err_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    cnt_d    = cnt_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    nack_d   = nack_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pass     = 1'b0;
    fail     = 1'b0;
    wd_hit   = (cnt_q == WD_LAST);
`ifdef PS2_TX_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_d  = ps2_frame(tx_data);
          state_d  = ST_INHIBIT;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          cnt_d    = '0;
          nack_d   = 1'b0;
`ifdef PS2_TX_RETRY_EN
          retry_d  = 1'b0;
`endif
        end
      end
      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d  = ST_RTS;
          dat_oe_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RTS: begin
        state_d  = ST_SHIFT;
        clk_oe_d = 1'b0;
        bitcnt_d = '0;
        cnt_d    = '0;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          cnt_d = '0;
          if (bitcnt_q == STOP_IDX) begin
            dat_oe_d = 1'b0;
            state_d  = ST_ACK;
          end else begin
            dat_oe_d = ~shreg_q[bitcnt_q];
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else if (wd_hit) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          nack_d  = dat_level;
          state_d = ST_WAIT_IDLE;
          cnt_d   = '0;
        end else if (wd_hit) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && dat_level) begin
          fail = nack_q;
          pass = ~nack_q;
        end else if (wd_hit) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pass) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        // Second attempt restarts from inhibit with the byte still in shreg.
        retry_d  = 1'b1;
        state_d  = ST_INHIBIT;
        clk_oe_d = 1'b1;
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        nack_d   = 1'b0;
      end else begin
        state_d  = ST_IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        done_d   = 1'b1;
        err_d    = 1'b1;
      end
`else
      state_d  = ST_IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      done_d   = 1'b1;
      err_d    = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      cnt_q    <= '0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      cnt_q    <= cnt_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      nack_q   <= nack_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

endmodule
